// File: rtl/serdes_link_test_ctrl_pkg.sv
// Shared types and constants for the SerDes link-test sequencer and its PRBS7 checker.
package serdes_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_TRAIN   = 3'd2,
        ST_LOCK    = 3'd3,
        ST_MEASURE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef enum logic {
        CHK_SEED = 1'b0,
        CHK_FREE = 1'b1
    } chk_mode_e;

    localparam int PRBS_W     = 7;
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    localparam int CNT_W_DEF        = 32;
    localparam int FLUSH_CYCLES_DEF = 64;
    localparam int TRAIN_BITS_DEF   = 4096;
    localparam int LOCK_RUN_DEF     = 32;
    localparam int LOCK_TIMEOUT_DEF = 1024;
    localparam int MEAS_BITS_DEF    = 1048576;

    // Next PRBS7 bit (x^7 + x^6 + 1) from a state whose bit 0 is the newest bit.
    function automatic logic prbs7_predict(input logic [PRBS_W-1:0] s);
        return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
    endfunction

endpackage

// File: rtl/serdes_link_test_ctrl_if.sv
// Control/status bundle between the link-test sequencer and its host / RX chain.
interface serdes_link_test_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic             rx_bit;
    logic             rx_bit_valid;
    logic             prbs_en;
    logic             dfe_train_en;
    logic             busy;
    logic             done;
    logic             lock_fail;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output start, abort, rx_bit, rx_bit_valid,
        input  prbs_en, dfe_train_en, busy, done, lock_fail, state_o, bit_count, err_count
    );

    modport slave (
        input  start, abort, rx_bit, rx_bit_valid,
        output prbs_en, dfe_train_en, busy, done, lock_fail, state_o, bit_count, err_count
    );
endinterface

// File: rtl/serdes_link_test_ctrl_prbs7_checker.sv
// PRBS7 checker: seed mode learns the stream and tracks a correct-prediction run,
// free-run mode predicts from its own state and flags each mismatching bit.
module prbs7_checker
    import serdes_test_pkg::*;
#(
    parameter int LOCK_RUN = LOCK_RUN_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear_i,
    input  chk_mode_e mode_i,
    input  logic      bit_i,
    input  logic      valid_i,
    output logic      err_o,
    output logic      run_ge_lock_o,
    output logic      seed_nonzero_o
);
    localparam int               RUN_W   = $clog2(LOCK_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_RUN);

    logic [PRBS_W-1:0] seed_q, seed_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              pred_s;
    logic              seed_nz_s;

    assign pred_s         = prbs7_predict(seed_q);
    assign seed_nz_s      = (seed_q != '0);
    assign seed_nonzero_o = seed_nz_s;

    // Next seed/run; err and run_ge_lock describe the bit presented this cycle.
    always_comb begin
        seed_d        = seed_q;
        run_d         = run_q;
        err_o         = 1'b0;
        run_ge_lock_o = 1'b0;
        if (!valid_i) begin
            seed_d = seed_q;
        end else if (mode_i == CHK_FREE) begin
            // Shifting our own prediction keeps one channel error from echoing via the taps.
            seed_d = {seed_q[PRBS_W-2:0], pred_s};
            err_o  = (bit_i != pred_s);
        end else begin
            seed_d = {seed_q[PRBS_W-2:0], bit_i};
            if (seed_nz_s && (bit_i == pred_s)) begin
                run_d = (run_q >= RUN_TGT) ? run_q : run_q + RUN_W'(1);
            end else begin
                run_d = '0;
            end
            run_ge_lock_o = (run_d >= RUN_TGT);
        end
    end

    // Checker state register.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            seed_q <= '0;
            run_q  <= '0;
        end else begin
            seed_q <= seed_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/serdes_link_test_ctrl.sv
// Link-test sequencer: PRBS enable, pipeline flush, DFE training, PRBS7 lock and
// windowed bit-error counting for one SerDes test run.
module serdes_link_test_ctrl
    import serdes_test_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int TRAIN_BITS   = TRAIN_BITS_DEF,
    parameter int LOCK_RUN     = LOCK_RUN_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int MEAS_BITS    = MEAS_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    serdes_link_test_ctrl_if.slave  link
);
    localparam logic [31:0]      FLUSH_LAST = 32'(FLUSH_CYCLES - 1);
    localparam logic [31:0]      TRAIN_LAST = 32'(TRAIN_BITS - 1);
    localparam logic [31:0]      TMO_LAST   = 32'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST  = CNT_W'(MEAS_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e           state_q;
    logic [31:0]      phase_q;
    logic [CNT_W-1:0] bit_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic             prbs_en_q;
    logic             dfe_train_en_q;
    logic             busy_q;
    logic             done_q;
    logic             lock_fail_q;

    logic             start_ok_s;
    logic             chk_valid_s;
    chk_mode_e        chk_mode_s;
    logic             chk_err_s;
    logic             chk_lock_s;
    logic             chk_seed_nz_s;
    logic             lock_hit_s;

    assign start_ok_s  = link.start && !link.abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign chk_valid_s = link.rx_bit_valid && ((state_q == ST_LOCK) || (state_q == ST_MEASURE));
    assign chk_mode_s  = (state_q == ST_MEASURE) ? CHK_FREE : CHK_SEED;
    assign lock_hit_s  = chk_lock_s && chk_seed_nz_s;

    prbs7_checker #(
        .LOCK_RUN (LOCK_RUN)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (start_ok_s),
        .mode_i         (chk_mode_s),
        .bit_i          (link.rx_bit),
        .valid_i        (chk_valid_s),
        .err_o          (chk_err_s),
        .run_ge_lock_o  (chk_lock_s),
        .seed_nonzero_o (chk_seed_nz_s)
    );

    // Run sequencer with phase counter, result counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            bit_count_q    <= '0;
            err_count_q    <= '0;
            prbs_en_q      <= 1'b0;
            dfe_train_en_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            lock_fail_q    <= 1'b0;
        end else if (link.abort) begin
            // Counters and lock_fail deliberately keep the last run's values.
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            prbs_en_q      <= 1'b0;
            dfe_train_en_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (link.start) begin
                        state_q     <= ST_FLUSH;
                        phase_q     <= '0;
                        bit_count_q <= '0;
                        err_count_q <= '0;
                        lock_fail_q <= 1'b0;
                        prbs_en_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (phase_q == FLUSH_LAST) begin
                        state_q        <= ST_TRAIN;
                        phase_q        <= '0;
                        dfe_train_en_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                ST_TRAIN: begin
                    if (link.rx_bit_valid) begin
                        if (phase_q == TRAIN_LAST) begin
                            state_q        <= ST_LOCK;
                            phase_q        <= '0;
                            dfe_train_en_q <= 1'b0;
                        end else begin
                            phase_q <= phase_q + 32'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (link.rx_bit_valid) begin
                        if (lock_hit_s) begin
                            state_q <= ST_MEASURE;
                            phase_q <= '0;
                        end else if (phase_q == TMO_LAST) begin
                            state_q     <= ST_DONE;
                            lock_fail_q <= 1'b1;
                            prbs_en_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            phase_q <= phase_q + 32'd1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (link.rx_bit_valid) begin
                        bit_count_q <= bit_count_q + CNT_W'(1);
                        if (chk_err_s && (err_count_q != CNT_MAX)) begin
                            err_count_q <= err_count_q + CNT_W'(1);
                        end
                        if (bit_count_q == MEAS_LAST) begin
                            state_q   <= ST_DONE;
                            prbs_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    phase_q        <= '0;
                    prbs_en_q      <= 1'b0;
                    dfe_train_en_q <= 1'b0;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b0;
                end
            endcase
        end
    end

    assign link.prbs_en      = prbs_en_q;
    assign link.dfe_train_en = dfe_train_en_q;
    assign link.busy         = busy_q;
    assign link.done         = done_q;
    assign link.lock_fail    = lock_fail_q;
    assign link.state_o      = state_q;
    assign link.bit_count    = bit_count_q;
    assign link.err_count    = err_count_q;

endmodule

// File: tb/tb_serdes_link_test_ctrl.sv
// Randomized directed bench for serdes_link_test_ctrl: a phase-by-phase reference built
// from the run rules predicts state, status and counters after every clock.
module tb_serdes_link_test_ctrl;

    localparam int A_CNTW = 32;
    localparam int B_CNTW = 4;
    localparam int P_F    = 4;
    localparam int P_T    = 16;
    localparam int P_LR   = 8;
    localparam int P_LTO  = 64;
    localparam int A_MEAS = 200;
    localparam int B_MEAS = 15;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serdes_link_test_ctrl_if #(.CNT_W(A_CNTW)) ia ();
    serdes_link_test_ctrl_if #(.CNT_W(B_CNTW)) ib ();

    serdes_link_test_ctrl #(
        .CNT_W(A_CNTW), .FLUSH_CYCLES(P_F), .TRAIN_BITS(P_T),
        .LOCK_RUN(P_LR), .LOCK_TIMEOUT(P_LTO), .MEAS_BITS(A_MEAS)
    ) dut_a (.clk(clk), .rst(rst_a), .link(ia));

    serdes_link_test_ctrl #(
        .CNT_W(B_CNTW), .FLUSH_CYCLES(P_F), .TRAIN_BITS(P_T),
        .LOCK_RUN(P_LR), .LOCK_TIMEOUT(P_LTO), .MEAS_BITS(B_MEAS)
    ) dut_b (.clk(clk), .rst(rst_b), .link(ib));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic ab, input logic b, input logic v);
        ia.start        = (sel == 0) ? st : 1'b0;
        ia.abort        = (sel == 0) ? ab : 1'b0;
        ia.rx_bit       = (sel == 0) ? b  : 1'b0;
        ia.rx_bit_valid = (sel == 0) ? v  : 1'b0;
        ib.start        = (sel == 1) ? st : 1'b0;
        ib.abort        = (sel == 1) ? ab : 1'b0;
        ib.rx_bit       = (sel == 1) ? b  : 1'b0;
        ib.rx_bit_valid = (sel == 1) ? v  : 1'b0;
    endtask

    // ph uses the published state numbering: 0 idle, 1 flush, 2 train, 3 lock, 4 measure, 5 done.
    task automatic check_all(input int sel, input int ph, input int bits, input int errs,
                             input int lf, input string tag);
        logic [31:0] st, bz, dn, pe, de, lfo, bc, ec, bmask;
        if (sel == 0) begin
            st = 32'(ia.state_o); bz = 32'(ia.busy); dn = 32'(ia.done);
            pe = 32'(ia.prbs_en); de = 32'(ia.dfe_train_en); lfo = 32'(ia.lock_fail);
            bc = ia.bit_count; ec = ia.err_count; bmask = 32'hFFFF_FFFF;
        end else begin
            st = 32'(ib.state_o); bz = 32'(ib.busy); dn = 32'(ib.done);
            pe = 32'(ib.prbs_en); de = 32'(ib.dfe_train_en); lfo = 32'(ib.lock_fail);
            bc = 32'(ib.bit_count); ec = 32'(ib.err_count); bmask = 32'h0000_000F;
        end
        chk({tag, ".state"}, st, 32'(ph));
        chk({tag, ".busy"}, bz, (ph >= 1 && ph <= 4) ? 32'd1 : 32'd0);
        chk({tag, ".done"}, dn, (ph == 5) ? 32'd1 : 32'd0);
        chk({tag, ".prbs_en"}, pe, (ph >= 1 && ph <= 4) ? 32'd1 : 32'd0);
        chk({tag, ".dfe_train_en"}, de, (ph == 2) ? 32'd1 : 32'd0);
        chk({tag, ".lock_fail"}, lfo, 32'(lf));
        chk({tag, ".bit_count"}, bc, 32'(bits) & bmask);
        chk({tag, ".err_count"}, ec, 32'(errs));
    endtask

    // One run: start, then each clock the reference decides stimulus and the expected outcome.
    task automatic do_run(input string tag, input int sel, input int pct, input bit zeros,
                          input bit inv_meas, input int flip_lock_k, input int flip_meas_k,
                          input int abort_k, input int rst_k, input bit noise);
        int        meas, emax, ph, nph, fcnt, tcnt, lcnt, run, k, n, mbits, merrs, mlf;
        bit        hist[$];
        bit        mseq[$];
        logic [6:0] gen;
        bit        vld, b, st, ab, rs, p, nz, e;
        meas  = (sel == 0) ? A_MEAS : B_MEAS;
        emax  = (sel == 0) ? 32'h7FFF_FFFF : 15;
        gen   = 7'h7F;
        fcnt  = 0; tcnt = 0; lcnt = 0; run = 0; mbits = 0; merrs = 0; mlf = 0;
        drive(sel, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        ph = 1;
        check_all(sel, ph, 0, 0, 0, {tag, ".start"});
        for (int c = 0; c < 4000 && ph >= 1 && ph <= 4; c++) begin
            vld = ($urandom_range(99) < pct);
            b   = 1'($urandom_range(1));
            st  = noise && ($urandom_range(7) == 0);
            ab  = 1'b0;
            rs  = 1'b0;
            nph = ph;
            if (vld) begin
                b   = gen[6] ^ gen[5];
                gen = {gen[5:0], b};
            end
            case (ph)
                1: begin
                    fcnt++;
                    if (fcnt == P_F) nph = 2;
                end
                2: begin
                    if (abort_k >= 0 && tcnt == abort_k) begin
                        ab = 1'b1; st = 1'b1; nph = 0;
                    end else if (vld) begin
                        tcnt++;
                        if (tcnt == P_T) nph = 3;
                    end
                end
                3: if (vld) begin
                    if (zeros) b = 1'b0;
                    if (lcnt == flip_lock_k) b = ~b;
                    k  = hist.size();
                    p  = ((k >= 7) ? hist[k-7] : 1'b0) ^ ((k >= 6) ? hist[k-6] : 1'b0);
                    nz = 1'b0;
                    for (int j = k - 7; j < k; j++) if (j >= 0) nz |= hist[j];
                    run = (nz && b == p) ? run + 1 : 0;
                    hist.push_back(b);
                    lcnt++;
                    if (run >= P_LR) begin
                        nph = 4;
                        k = hist.size();
                        for (int j = k - 7; j < k; j++) mseq.push_back((j >= 0) ? hist[j] : 1'b0);
                    end else if (lcnt == P_LTO) begin
                        nph = 5; mlf = 1;
                    end
                end
                4: if (vld) begin
                    if (rst_k >= 0 && mbits == rst_k) begin
                        rs = 1'b1; nph = 0;
                    end else begin
                        n = mseq.size();
                        e = mseq[n-7] ^ mseq[n-6];
                        mseq.push_back(e);
                        if (inv_meas) b = ~b;
                        if (mbits == flip_meas_k) b = ~b;
                        if (b != e && merrs < emax) merrs++;
                        mbits++;
                        if (mbits == meas) nph = 5;
                    end
                end
                default: ;
            endcase
            drive(sel, st, ab, b, vld);
            if (rs) begin
                if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
            end
            tick();
            rst_a = 1'b0;
            rst_b = 1'b0;
            ph = nph;
            if (rs) begin
                mbits = 0; merrs = 0; mlf = 0;
            end
            check_all(sel, ph, mbits, merrs, mlf, tag);
        end
        chk({tag, ".terminated"}, 32'((ph == 0) || (ph == 5)), 32'd1);
        // Quiet period: stray valid bits must not disturb held results.
        for (int c = 0; c < 6; c++) begin
            drive(sel, 1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            tick();
            check_all(sel, ph, mbits, merrs, mlf, {tag, ".hold"});
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        check_all(0, 0, 0, 0, 0, "reset_a");
        check_all(1, 0, 0, 0, 0, "reset_b");

        do_run("clean",       0, 100, 1'b0, 1'b0, -1, -1, -1, -1, 1'b0);
        do_run("single_err",  0,  70, 1'b0, 1'b0, -1, 50, -1, -1, 1'b1);
        do_run("lock_tmo",    0,  60, 1'b1, 1'b0, -1, -1, -1, -1, 1'b0);
        do_run("lock_recov",  0,  80, 1'b0, 1'b0,  4, -1, -1, -1, 1'b0);
        do_run("abort_train", 0,  75, 1'b0, 1'b0, -1, -1,  5, -1, 1'b0);
        do_run("after_abort", 0, 100, 1'b0, 1'b0, -1, -1, -1, -1, 1'b1);
        do_run("saturate",    1,  90, 1'b0, 1'b1, -1, -1, -1, -1, 1'b0);
        do_run("rst_meas",    1,  90, 1'b0, 1'b0, -1, -1, -1,  7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
